// File: rtl/pll_pkg.sv
// ---------------------------------------------------------------------------
// pll_pkg
// Shared definitions for the PLL divider family (N feedback divider, M
// reference divider). Holds the legal divide-ratio limits so every divider
// range-checks its ratio against the same numbers.
// ---------------------------------------------------------------------------
package pll_pkg;

    // Smallest and largest division ratio any PLL divider accepts.
    localparam int N_MIN = 2;
    localparam int N_MAX = 65535;

endpackage : pll_pkg

// File: rtl/n_divide.sv
// ---------------------------------------------------------------------------
// n_divide
// Feedback ("N") divider for the PLL. Divides clk_out by the compile-time
// ratio N and produces clk_fb for the phase-frequency detector. clk_fb is a
// registered, glitch-free square wave with a period of N clk_out cycles. Each
// period is low for ceil(N/2) cycles and then high for floor(N/2) cycles.
//
// Parameters
//   N        division ratio, N_MIN..N_MAX
//   CNT_W    counter width, derived from N (do not override)
//   HIGH_CYC clk_out cycles per period with clk_fb high, derived (floor(N/2))
//
// Ports
//   clk_out  in   PLL output clock, the only clock in this block
//   rst_n    in   synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   clk_fb   out  divided feedback clock, driven straight from a flop
// ---------------------------------------------------------------------------
module n_divide
    import pll_pkg::*;
#(
    parameter int N        = 8,
    parameter int CNT_W    = $clog2(N),
    parameter int HIGH_CYC = N / 2
) (
    input  logic clk_out,
    input  logic rst_n,
    output logic clk_fb
);

    // Elaboration-time guards: the ratio must be legal, and the derived
    // parameters must keep the values computed from N.
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("n_divide: N=%0d is outside the legal range %0d..%0d", N, N_MIN, N_MAX);
    end
    if (CNT_W != $clog2(N) || HIGH_CYC != N / 2) begin : g_bad_derived
        $error("n_divide: CNT_W and HIGH_CYC are derived from N and must not be overridden");
    end

    // Terminal count, and the count at which the high phase begins.
    // N - HIGH_CYC = ceil(N/2), which is always at most N-1, so it fits in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(N - HIGH_CYC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_fb_q;

    // The compare uses the full count value. For N that is not a power of two,
    // counts at or above N are therefore never reached.
    // NOTE: each signal written in always_comb gets a value on every path;
    // this is what keeps the block from inferring a latch.
    always_comb begin
        cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

    // The output flop decodes the next count rather than the current one.
    // This places clk_fb in step with cnt, so the wrap from N-1 to 0 is the
    // same edge as the falling edge of clk_fb.
    // NOTE: the reset is synchronous, so it is sampled only on the clock edge
    // and is absent from the sensitivity list. Sequential state uses
    // non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk_out) begin
        if (rst_n) begin
            cnt      <= '0;
            clk_fb_q <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            clk_fb_q <= (cnt_nxt >= HIGH_START);
        end
    end

    assign clk_fb = clk_fb_q;

    // The counter must never leave the range 0..N-1 while running.
    a_cnt_range : assert property (@(posedge clk_out) disable iff (rst_n) int'(cnt) < N);

endmodule : n_divide

// File: tb/tb_n_divide.sv
// ---------------------------------------------------------------------------
// tb_n_divide
// Directed bench for n_divide. It runs four instances (N = 8, 5, 2, 10) from
// one 10 ns clock, and each instance has its own reset. Instances are released
// one at a time. The expected clk_fb level after k edges comes from the
// waveform definition: phase = k mod N, and clk_fb is low for the first
// ceil(N/2) phases and high for the rest. Outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_n_divide;

    logic clk = 1'b0;
    logic rst8 = 1'b1, rst5 = 1'b1, rst2 = 1'b1, rst10 = 1'b1;
    logic fb8, fb5, fb2, fb10;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    n_divide #(.N(8))  dut8  (.clk_out(clk), .rst_n(rst8),  .clk_fb(fb8));
    n_divide #(.N(5))  dut5  (.clk_out(clk), .rst_n(rst5),  .clk_fb(fb5));
    n_divide #(.N(2))  dut2  (.clk_out(clk), .rst_n(rst2),  .clk_fb(fb2));
    n_divide #(.N(10)) dut10 (.clk_out(clk), .rst_n(rst10), .clk_fb(fb10));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clk_out cycle and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected clk_fb after k edges since reset release: the low phase is
    // ceil(n/2) cycles long and comes first.
    function automatic logic exp_fb(input int n, input int k);
        int phase;
        phase = k % n;
        return logic'(phase >= (n + 1) / 2);
    endfunction

    initial begin
        int rises;
        int highs;
        logic prev;

        // All instances in reset for two edges: outputs low and counter cleared.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_hold_fb8",  32'(fb8),  32'd0);
            check("reset_hold_cnt8", 32'(dut8.cnt), 32'd0);
            check("reset_hold_fb5",  32'(fb5),  32'd0);
            check("reset_hold_fb2",  32'(fb2),  32'd0);
            check("reset_hold_fb10", 32'(fb10), 32'd0);
        end

        // N = 8: ten periods. The first high is at edge 4, and the pattern
        // repeats every 8 edges.
        rst8 = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            check($sformatf("n8_edge%0d", k), 32'(fb8), 32'(exp_fb(8, k)));
        end
        check("n8_first_high_edge4", 32'(exp_fb(8, 4)), 32'd1);

        // Run to cnt = 6 (inside the high phase), then reset mid-period.
        for (int k = 1; k <= 6; k++) tick();
        check("n8_pre_reset_fb",  32'(fb8),      32'd1);
        check("n8_pre_reset_cnt", 32'(dut8.cnt), 32'd6);
        rst8 = 1'b1;
        tick();
        check("n8_mid_reset_fb",  32'(fb8),      32'd0);
        check("n8_mid_reset_cnt", 32'(dut8.cnt), 32'd0);

        // After release the sequence restarts, with the first high again at edge 4.
        rst8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("n8_restart_edge%0d", k), 32'(fb8), 32'(exp_fb(8, k)));
        end

        // Reset applied on the edge that would have raised clk_fb: the reset takes effect.
        for (int k = 1; k <= 3; k++) tick();
        check("n8_cnt3", 32'(dut8.cnt), 32'd3);
        rst8 = 1'b1;
        tick();
        check("n8_reset_vs_rise_fb",  32'(fb8),      32'd0);
        check("n8_reset_vs_rise_cnt", 32'(dut8.cnt), 32'd0);

        // N = 5 (odd): low for 3 cycles, then high for 2.
        rst5 = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("n5_edge%0d", k), 32'(fb5), 32'(exp_fb(5, k)));
        end

        // N = 2: clk_fb toggles on every edge and is high after the first edge.
        rst2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("n2_edge%0d", k), 32'(fb2), 32'(k % 2));
        end

        // N = 10 for 1000 ns: expect exactly 10 rising edges and 50 high cycles.
        rst10 = 1'b0;
        rises = 0;
        highs = 0;
        prev  = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            check($sformatf("n10_edge%0d", k), 32'(fb10), 32'(exp_fb(10, k)));
            if (fb10 === 1'b1) highs++;
            if (fb10 === 1'b1 && prev === 1'b0) rises++;
            prev = fb10;
        end
        check("n10_rising_edges", 32'(rises), 32'd10);
        check("n10_high_cycles",  32'(highs), 32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_n_divide

// File: doc/n_divide.md
Name: n_divide

Overview:
- Feedback ("N") divider for the PLL.
- Divides the synthesized output clock clk_out by a compile-time integer N and produces the feedback clock clk_fb for the phase-frequency detector.
- Fully synchronous to clk_out.
- clk_fb is a registered, glitch-free square wave with period N clk_out cycles.

Parameters:
- N, default 8: division ratio. Legal range 2..65535. Elaboration-time error (assertion or $error in a generate check) if N < 2.
- CNT_W, default $clog2(N): counter width. It is derived and must not be overridden.
- HIGH_CYC, default N/2 (integer floor): number of clk_out cycles clk_fb is high per period. It is derived.

Ports:
- clk_out  input  1  Sole clock: the PLL output clock. All state updates on its rising edge.
- rst_n  input  1  Synchronous, active-high reset. The name is kept per codebase convention; asserted = 1.
- clk_fb  output  1  Divided feedback clock, driven directly from a flop.

Behaviour:
- One clock: clk_out. Reset is synchronous and active-high. There is no asynchronous path.
- State: a counter cnt[CNT_W-1:0] and an output flop clk_fb_q. clk_fb = clk_fb_q, with no combinational logic on the output.
- Reset (rst_n = 1 at a rising edge): cnt <= 0, clk_fb_q <= 0. While held in reset, clk_fb stays 0.
- Normal operation (rst_n = 0 at a rising edge):
  - cnt_nxt = (cnt == N-1) ? 0 : cnt + 1; cnt <= cnt_nxt.
  - clk_fb_q <= (cnt_nxt >= N - HIGH_CYC).
- Waveform per period: low for N - HIGH_CYC cycles (= ceil(N/2)), then high for HIGH_CYC cycles (= floor(N/2)).
  - Even N gives exactly 50% duty.
  - Odd N gives a low phase one cycle longer than the high phase.
- Latency:
  - First rising edge of clk_fb occurs on the (N - HIGH_CYC)-th rising edge of clk_out after the first non-reset edge.
  - Subsequent rising edges follow every N clk_out cycles exactly.
- Wrap-around: cnt never exceeds N-1. Wrap from N-1 to 0 coincides with the falling edge of clk_fb.
- N = 2: clk_fb toggles every clk_out edge (divide-by-2). No special case is required.
- Non-power-of-2 N: the compare is on the full cnt value, so no unused counts are reachable.
- Reset mid-operation: on the reset edge, cnt = 0 and clk_fb = 0 regardless of phase. After release, the sequence restarts from the reset-release latency above.
- Simultaneous reset and wrap: reset wins.
- Before the first reset edge, state is X. The bench must apply reset before checking.

Decomposition:
- A shared pll_pkg holds the common divide-ratio limits, used by n_divide and any sibling dividers (M/reference divider):
  - localparam N_MIN = 2
  - localparam N_MAX = 65535
- No sub-module. Counter and output flop live in one module.
- Optional: synthesis-off SVA in the same file.
  - Check 1: cnt < N at every edge.
  - Check 2: the clk_fb period equals N when not in reset.

Test Plan:
- Reset hold: rst_n = 1 for 2 clk_out edges (10 ns period) -> clk_fb = 0 and cnt = 0 throughout.
- N = 8 steady state: release reset -> clk_fb goes high on the 4th edge after release, stays high 4 cycles, low 4 cycles. Period is 80 ns; check over 10 periods.
- N = 5 (odd): release reset -> low 3 cycles, high 2 cycles, period 5 cycles. First high on the 3rd edge after release.
- N = 2: release reset -> clk_fb toggles every edge, starting high on the 1st edge after release (period 20 ns).
- Reset mid-period, N = 8: assert rst_n while clk_fb is high (cnt = 6) -> next edge clk_fb = 0. After release, first high again on the 4th edge.
- N = 10 long run: 1000 ns of clock -> count exactly N-cycle periods with 50% duty; SVA cnt <= 9 never fires.
